// File: rtl/bp_me_mem_fwd_arbiter.sv
// bp_me_mem_fwd_arbiter: shares one BedRock stream memory port among num_req_p
// requesters, with round-robin arbitration per message (the grant is held from
// the first to the last beat) and in-order steering of responses.
//
// Ports:
//   clk_i, reset_n_i      clock (rising edge) and async active-low reset
//   req_fwd_*             per-requester fwd streams in (header/data/v/last), ready out
//   req_rev_*             rev stream out; header/data/last broadcast, v one-hot to owner
//   mem_fwd_*             single fwd stream to memory
//   mem_rev_*             single rev stream from memory (responses in request order)
//   error_o               sticky: memory sent a rev beat with nothing outstanding
//
// Latency: 0 cycles through both muxes; throughput 1 beat/cycle each direction.
// Backpressure: mem_fwd ready goes to the granted requester only; mem_rev ready
// follows the owner's ready. A full tag FIFO blocks new grants.

// Tag FIFO: in-order record of which requester owns each outstanding message.
//   push_i/data_i  enqueue a requester index (ignored when full)
//   pop_i          dequeue the head (ignored when empty)
//   data_o         head tag; full_o/empty_o status from registered count only
module bp_me_mem_fwd_arbiter_tag_fifo #(
  parameter int width_p = 1,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               push_i,
  input  logic [width_p-1:0] data_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1;

  logic [width_p-1:0]   mem_r [els_p];
  logic [lg_els_lp-1:0] wptr_r;
  logic [lg_els_lp-1:0] rptr_r;
  logic [lg_els_lp:0]   count_r;
  logic                 do_push;
  logic                 do_pop;

  // Status comes only from the registered count, so a pop never opens room for
  // a push in the same cycle and there is no rev->fwd combinational path.
  assign full_o  = (count_r == (lg_els_lp+1)'(els_p));
  assign empty_o = (count_r == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_r[rptr_r];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_r[wptr_r] <= data_i;
    end
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (do_push) begin
        wptr_r <= wptr_r + 1'b1;
      end
      if (do_pop) begin
        rptr_r <= rptr_r + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

module bp_me_mem_fwd_arbiter #(
  parameter int num_req_p      = 2,
  parameter int header_width_p = 128,
  parameter int data_width_p   = 64,
  parameter int outstanding_p  = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,

  input  logic [num_req_p*header_width_p-1:0] req_fwd_header_i,
  input  logic [num_req_p*data_width_p-1:0]   req_fwd_data_i,
  input  logic [num_req_p-1:0]                req_fwd_v_i,
  input  logic [num_req_p-1:0]                req_fwd_last_i,
  output logic [num_req_p-1:0]                req_fwd_ready_and_o,

  output logic [num_req_p*header_width_p-1:0] req_rev_header_o,
  output logic [num_req_p*data_width_p-1:0]   req_rev_data_o,
  output logic [num_req_p-1:0]                req_rev_v_o,
  output logic [num_req_p-1:0]                req_rev_last_o,
  input  logic [num_req_p-1:0]                req_rev_ready_and_i,

  output logic [header_width_p-1:0]           mem_fwd_header_o,
  output logic [data_width_p-1:0]             mem_fwd_data_o,
  output logic                                mem_fwd_v_o,
  output logic                                mem_fwd_last_o,
  input  logic                                mem_fwd_ready_and_i,

  input  logic [header_width_p-1:0]           mem_rev_header_i,
  input  logic [data_width_p-1:0]             mem_rev_data_i,
  input  logic                                mem_rev_v_i,
  input  logic                                mem_rev_last_i,
  output logic                                mem_rev_ready_and_o,

  output logic                                error_o
);

  localparam int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_lock = 1'b1
  } state_e;

  state_e                 state_r, state_n;
  logic [lg_req_lp-1:0]   grant_r, grant_n;
  logic [lg_req_lp-1:0]   rr_r, rr_n;

  logic [lg_req_lp-1:0]   cand;
  logic                   cand_v;
  logic [lg_req_lp-1:0]   sel;
  logic                   fwd_open;
  logic                   push;

  logic [lg_req_lp-1:0]   head_tag;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   rev_open;
  logic                   pop;
  logic                   error_r;

  function automatic logic [lg_req_lp-1:0] wrap_inc(input logic [lg_req_lp-1:0] a);
    return (int'(a) == num_req_p - 1) ? '0 : a + 1'b1;
  endfunction

  // Round-robin candidate: first valid requester scanning rr_r, rr_r+1, ...
  // Scanning from the farthest offset down lets the nearest one win.
  always_comb begin
    cand   = rr_r;
    cand_v = 1'b0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      if (req_fwd_v_i[lg_req_lp'((int'(rr_r) + i) % num_req_p)]) begin
        cand   = lg_req_lp'((int'(rr_r) + i) % num_req_p);
        cand_v = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      grant_r <= '0;
      rr_r    <= '0;
    end else begin
      state_r <= state_n;
      grant_r <= grant_n;
      rr_r    <= rr_n;
    end
  end

  // Next state plus mux select. fwd_open says the selected requester is
  // connected to memory this cycle; in IDLE it also requires a free tag slot.
  always_comb begin
    state_n  = state_r;
    grant_n  = grant_r;
    rr_n     = rr_r;
    sel      = cand;
    fwd_open = 1'b0;
    push     = 1'b0;
    case (state_r)
      e_idle: begin
        sel      = cand;
        fwd_open = cand_v & ~fifo_full;
        if (fwd_open & mem_fwd_ready_and_i) begin
          push = 1'b1;
          if (req_fwd_last_i[cand]) begin
            rr_n = wrap_inc(cand);
          end else begin
            grant_n = cand;
            state_n = e_lock;
          end
        end
      end
      e_lock: begin
        // The tag was pushed on the first beat; the rest of the message only
        // needs the mux held. A dropped valid simply stalls here.
        sel      = grant_r;
        fwd_open = 1'b1;
        if (req_fwd_v_i[grant_r] & mem_fwd_ready_and_i & req_fwd_last_i[grant_r]) begin
          rr_n    = wrap_inc(grant_r);
          state_n = e_idle;
        end
      end
      default: begin
        state_n = e_idle;
      end
    endcase
  end

  // Fwd mux. Valid/ready are forced low while reset is asserted.
  assign mem_fwd_header_o = req_fwd_header_i[int'(sel)*header_width_p +: header_width_p];
  assign mem_fwd_data_o   = req_fwd_data_i[int'(sel)*data_width_p +: data_width_p];
  assign mem_fwd_last_o   = req_fwd_last_i[sel];
  assign mem_fwd_v_o      = reset_n_i & fwd_open & req_fwd_v_i[sel];

  always_comb begin
    req_fwd_ready_and_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      req_fwd_ready_and_o[i] = reset_n_i & fwd_open & mem_fwd_ready_and_i
                             & (sel == lg_req_lp'(i));
    end
  end

  bp_me_mem_fwd_arbiter_tag_fifo #(
    .width_p (lg_req_lp),
    .els_p   (outstanding_p)
  ) tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (push),
    .data_i    (sel),
    .pop_i     (pop),
    .data_o    (head_tag),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Rev path: the head tag owns every beat until the beat marked last.
  assign rev_open            = reset_n_i & ~fifo_empty;
  assign mem_rev_ready_and_o = rev_open & req_rev_ready_and_i[head_tag];
  assign pop                 = mem_rev_v_i & mem_rev_ready_and_o & mem_rev_last_i;

  assign req_rev_header_o = {num_req_p{mem_rev_header_i}};
  assign req_rev_data_o   = {num_req_p{mem_rev_data_i}};
  assign req_rev_last_o   = {num_req_p{mem_rev_last_i}};

  always_comb begin
    req_rev_v_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      req_rev_v_o[i] = rev_open & mem_rev_v_i & (head_tag == lg_req_lp'(i));
    end
  end

  // A response with nothing outstanding cannot be routed; flag it and hold.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      error_r <= 1'b0;
    end else if (mem_rev_v_i & fifo_empty) begin
      error_r <= 1'b1;
    end
  end

  assign error_o = error_r;

endmodule
